// File: rtl/dmx_frame_tx_if.sv
// Bus bundle for dmx_frame_tx: serial output, frame control, slot RAM
// write port and status. The commit line only exists when
// DMX_TX_DOUBLE_BUFFER_EN is defined.
interface dmx_frame_tx_if;
    logic       tx;
    logic       start;
    logic       repeat_en;
    logic [9:0] slot_count;
    logic [7:0] start_code;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_done;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
    logic       commit;

    modport master (
        input  tx, busy, frame_done,
        output start, repeat_en, slot_count, start_code,
        output wr_en, wr_addr, wr_data, commit
    );

    modport slave (
        output tx, busy, frame_done,
        input  start, repeat_en, slot_count, start_code,
        input  wr_en, wr_addr, wr_data, commit
    );
`else
    modport master (
        input  tx, busy, frame_done,
        output start, repeat_en, slot_count, start_code,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output tx, busy, frame_done,
        input  start, repeat_en, slot_count, start_code,
        input  wr_en, wr_addr, wr_data
    );
`endif
endinterface

// File: rtl/dmx_frame_tx.sv
// DMX512 frame transmitter: break, mark-after-break, start code, then
// 1..512 slot bytes from the slot RAM, 11 bit times per character
// (start, 8 data LSB first, 2 stop). Optional feature macro:
// DMX_TX_DOUBLE_BUFFER_EN selects two slot banks with a commit-driven swap.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line at mark, waiting for start or repeat_en
// S_BREAK | line low for BREAK_BITS bit times
// S_MAB   | line high for MAB_BITS bit times
// S_CHAR  | shifting one character; chains straight into the next one
module dmx_frame_tx #(
    parameter int unsigned BAUD_DIV   = 159,
    parameter int unsigned BREAK_BITS = 22,
    parameter int unsigned MAB_BITS   = 2
) (
    input  logic          CLK_40,
    input  logic          reset_n,
    dmx_frame_tx_if.slave bus
);

    localparam int unsigned BAUD_W  = (BAUD_DIV > 0) ? $clog2(BAUD_DIV + 1) : 1;
    localparam int unsigned BIT_MAX = (BREAK_BITS > MAB_BITS)
                                    ? ((BREAK_BITS > 11) ? BREAK_BITS : 11)
                                    : ((MAB_BITS > 11) ? MAB_BITS : 11);
    localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);

    localparam logic [BAUD_W-1:0] BAUD_LOAD  = BAUD_W'(BAUD_DIV);
    localparam logic [BIT_W-1:0]  BREAK_LOAD = BIT_W'(BREAK_BITS - 1);
    localparam logic [BIT_W-1:0]  MAB_LOAD   = BIT_W'(MAB_BITS - 1);
    localparam logic [BIT_W-1:0]  CHAR_LOAD  = BIT_W'(10);
    localparam logic [9:0]        MAX_SLOTS  = 10'd512;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAB   = 2'd2,
        S_CHAR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [9:0]        char_idx_q, char_idx_d;
    logic [9:0]        count_q, count_d;
    logic [7:0]        code_q, code_d;
    logic [8:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              rd_en;
    logic [7:0]        rd_data_q;

`ifdef DMX_TX_DOUBLE_BUFFER_EN
    localparam int unsigned MEM_AW = 10;
    logic bank_q, bank_d;
    logic pend_q, pend_d;
`else
    localparam int unsigned MEM_AW = 9;
`endif

    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic [7:0]        mem_q [0:(1 << MEM_AW) - 1];

    // Character k+1 needs RAM[k], so the current char index is the fetch address.
`ifdef DMX_TX_DOUBLE_BUFFER_EN
    assign wr_idx = {~bank_q, bus.wr_addr};
    assign rd_idx = {bank_q, char_idx_q[8:0]};
`else
    assign wr_idx = bus.wr_addr;
    assign rd_idx = char_idx_q[8:0];
`endif

    assign tick           = (baud_q == '0);
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        char_idx_d = char_idx_q;
        count_d    = count_q;
        code_d     = code_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
        bank_d     = bank_q;
        pend_d     = pend_q | bus.commit;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start || bus.repeat_en) begin
                    state_d    = S_BREAK;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_d     = BAUD_LOAD;
                    bit_d      = BREAK_LOAD;
                    char_idx_d = '0;
                    count_d    = (bus.slot_count > MAX_SLOTS) ? MAX_SLOTS : bus.slot_count;
                    code_d     = bus.start_code;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
                    // A commit arriving on this very clock is kept for the next frame.
                    if (pend_q) begin
                        bank_d = ~bank_q;
                        pend_d = bus.commit;
                    end
`endif
                end
            end
            S_BREAK: begin
                baud_d = tick ? BAUD_LOAD : baud_q - BAUD_W'(1);
                if (tick) begin
                    if (bit_q == '0) begin
                        state_d = S_MAB;
                        tx_d    = 1'b1;
                        bit_d   = MAB_LOAD;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            S_MAB: begin
                baud_d = tick ? BAUD_LOAD : baud_q - BAUD_W'(1);
                if (tick) begin
                    if (bit_q == '0) begin
                        state_d    = S_CHAR;
                        tx_d       = 1'b0;
                        bit_d      = CHAR_LOAD;
                        char_idx_d = '0;
                        shift_d    = {1'b1, code_q};
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            S_CHAR: begin
                baud_d = tick ? BAUD_LOAD : baud_q - BAUD_W'(1);
                // Fetch the next slot byte at the boundary into the second stop bit.
                rd_en  = tick && (bit_q == BIT_W'(1));
                if (tick) begin
                    if (bit_q == '0) begin
                        if (char_idx_q == count_q) begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            char_idx_d = char_idx_q + 10'd1;
                            tx_d       = 1'b0;
                            bit_d      = CHAR_LOAD;
                            shift_d    = {1'b1, rd_data_q};
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[8:1]};
                        bit_d   = bit_q - BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset abandons any character in flight.
    always_ff @(posedge CLK_40) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            char_idx_q <= '0;
            count_q    <= '0;
            code_q     <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            char_idx_q <= char_idx_d;
            count_q    <= count_d;
            code_q     <= code_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
            bank_q     <= bank_d;
            pend_q     <= pend_d;
`endif
        end
    end

    // Slot RAM: read-before-write, so a same-clock write returns the old byte.
    always_ff @(posedge CLK_40) begin
        if (bus.wr_en) begin
            mem_q[wr_idx] <= bus.wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_dmx_frame_tx.sv
// Bench for dmx_frame_tx with a shortened bit period. The reference model
// builds each frame as a list of bit levels from the latched slot count,
// start code and a model of the slot RAM, then compares tx cycle by cycle.
module tb_dmx_frame_tx;

    localparam int BD = 3;
    localparam int P  = BD + 1;
    localparam int BB = 22;
    localparam int MB = 2;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmx_frame_tx_if bus_if ();

    dmx_frame_tx #(
        .BAUD_DIV   (BD),
        .BREAK_BITS (BB),
        .MAB_BITS   (MB)
    ) dut (
        .CLK_40  (clk),
        .reset_n (rst_n),
        .bus     (bus_if.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] ram_m [0:1][0:511];
    int act  = 0;
    bit pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wbank();
        return DB ? (act ^ 1) : act;
    endfunction

    task automatic write_ram(input logic [8:0] a, input logic [7:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        @(posedge clk); #1;
        bus_if.wr_en   = 1'b0;
        ram_m[wbank()][a] = d;
    endtask

    task automatic publish();
`ifdef DMX_TX_DOUBLE_BUFFER_EN
        bus_if.commit = 1'b1;
        @(posedge clk); #1;
        bus_if.commit = 1'b0;
        pend = 1'b1;
`endif
    endtask

    task automatic write_all();
        for (int i = 0; i < 512; i++) begin
            write_ram(9'(i), 8'($urandom));
        end
    endtask

    // One complete frame; called #1 after a clock edge.
    task automatic run_frame(input bit do_start, input bit keep_repeat, input int n_req,
                             input logic [7:0] code, input int ms_cycle, input int wr_cycle,
                             input logic [8:0] wa, input logic [7:0] wd, input bit do_commit,
                             input string tag);
        bit         exp_bits[$];
        logic [7:0] byte_v;
        int         n, len, errs, first_bad;

        n = (n_req > 512) ? 512 : n_req;
        bus_if.slot_count = 10'(n_req);
        bus_if.start_code = code;
        if (do_start) bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;

        if (pend) begin
            act  = act ^ 1;
            pend = 1'b0;
        end
        if (wr_cycle >= 0) ram_m[wbank()][wa] = wd;
        if (do_commit) pend = 1'b1;

        exp_bits = {};
        repeat (BB) exp_bits.push_back(1'b0);
        repeat (MB) exp_bits.push_back(1'b1);
        for (int k = 0; k <= n; k++) begin
            byte_v = (k == 0) ? code : ram_m[act][k-1];
            exp_bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) exp_bits.push_back(byte_v[b]);
            exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b1);
        end

        len = (BB + MB + 11 * (n + 1)) * P;
        errs = 0;
        first_bad = -1;
        for (int c = 0; c < len; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            bus_if.wr_en = 1'b0;
            bus_if.start = 1'b0;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
            bus_if.commit = 1'b0;
`endif
            if (c == 10) begin
                bus_if.slot_count = 10'($urandom_range(0, 1023));
                bus_if.start_code = 8'($urandom);
            end
            if (c == ms_cycle) bus_if.start = 1'b1;
            if (c == wr_cycle) begin
                bus_if.wr_en   = 1'b1;
                bus_if.wr_addr = wa;
                bus_if.wr_data = wd;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
                bus_if.commit  = do_commit;
`endif
            end
            if (bus_if.tx !== exp_bits[c / P] || bus_if.busy !== 1'b1 || bus_if.frame_done !== 1'b0) begin
                if (errs == 0) first_bad = c;
                errs++;
            end
        end
        check({tag, " cycles with wrong tx/busy/done (first bad cycle in note)"}, 32'(errs), 32'd0);
        if (errs != 0) $display("note: %s first bad cycle %0d", tag, first_bad);

        @(posedge clk); #1;
        bus_if.wr_en = 1'b0;
        bus_if.start = 1'b0;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
        bus_if.commit = 1'b0;
`endif
        check({tag, " frame_done at frame length"}, 32'(bus_if.frame_done), 32'd1);
        check({tag, " busy low with frame_done"}, 32'(bus_if.busy), 32'd0);
        check({tag, " tx idle at frame_done"}, 32'(bus_if.tx), 32'd1);

        if (!keep_repeat) begin
            bus_if.repeat_en = 1'b0;
            @(posedge clk); #1;
            check({tag, " frame_done one clock wide"}, 32'(bus_if.frame_done), 32'd0);
            check({tag, " stays idle after frame"}, {30'd0, bus_if.tx, bus_if.busy}, 32'd2);
        end
    endtask

    initial begin
        int n_rand;

        rst_n             = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.repeat_en  = 1'b0;
        bus_if.slot_count = '0;
        bus_if.start_code = '0;
        bus_if.wr_en      = 1'b0;
        bus_if.wr_addr    = '0;
        bus_if.wr_data    = '0;
`ifdef DMX_TX_DOUBLE_BUFFER_EN
        bus_if.commit     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(bus_if.tx), 32'd1);
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset frame_done", 32'(bus_if.frame_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill both banks (one bank when single-buffered) with known bytes.
        write_all();
        publish();
        run_frame(1, 0, 0, 8'h5A, -1, -1, 9'd0, 8'd0, 0, "init");
        write_all();

        write_ram(9'd0, 8'h11);
        write_ram(9'd1, 8'h22);
        write_ram(9'd2, 8'h33);
        publish();
        run_frame(1, 0, 3, 8'h00, -1, -1, 9'd0, 8'd0, 0, "three_slots");

        run_frame(1, 0, 0, 8'hCC, -1, -1, 9'd0, 8'd0, 0, "code_only");

        run_frame(1, 0, 700, 8'($urandom), -1, -1, 9'd0, 8'd0, 0, "clamp_512");

        bus_if.repeat_en = 1'b1;
        run_frame(1, 1, 2, 8'hA5, -1, -1, 9'd0, 8'd0, 0, "repeat0");
        run_frame(0, 1, 5, 8'($urandom), 60, -1, 9'd0, 8'd0, 0, "repeat1_midstart");
        run_frame(0, 0, 1, 8'($urandom), -1, -1, 9'd0, 8'd0, 0, "repeat2");

        for (int i = 0; i < 4; i++) begin
            n_rand = $urandom_range(0, 40);
            run_frame(1, 0, n_rand, 8'($urandom), (i == 0) ? 150 : -1, -1, 9'd0, 8'd0, 0,
                      $sformatf("random%0d", i));
        end

`ifdef DMX_TX_DOUBLE_BUFFER_EN
        write_ram(9'd0, 8'h55);
        publish();
        run_frame(1, 0, 1, 8'h01, -1, -1, 9'd0, 8'd0, 0, "db_prepare");
        run_frame(1, 0, 1, 8'h02, (BB + MB + 11) * P + 3, -1 + (BB + MB + 11) * P + 4, 9'd0, 8'hAA, 1, "db_old_bank");
        run_frame(1, 0, 1, 8'h03, -1, -1, 9'd0, 8'd0, 0, "db_new_bank");
`else
        run_frame(1, 0, 8, 8'h07, -1, (BB + MB + 22) * P + 5, 9'd5, 8'hAA, 0, "live_write_slot5");
`endif

        // Reset for one clock in the middle of slot 2.
        bus_if.slot_count = 10'd3;
        bus_if.start_code = 8'h42;
        bus_if.start      = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat ((BB + MB + 22) * P + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midframe reset tx", 32'(bus_if.tx), 32'd1);
        check("midframe reset busy", 32'(bus_if.busy), 32'd0);
        check("midframe reset frame_done", 32'(bus_if.frame_done), 32'd0);
        act  = 0;
        pend = 1'b0;
        @(posedge clk); #1;
        check("after reset still idle", {30'd0, bus_if.tx, bus_if.busy}, 32'd2);
        run_frame(1, 0, 3, 8'h42, -1, -1, 9'd0, 8'd0, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
